// File: rtl/alu_pkg.sv
// Shared types, constants and the golden ALU model, used by alu_bist and its bench.
package alu_pkg;

  localparam int          ALU_W     = 32;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_XOR = 4'd3,
    OP_SLL = 4'd4,
    OP_SRL = 4'd5,
    OP_SUB = 4'd6,
    OP_SRA = 4'd7
  } alu_op_e;

  // One Galois step: shift right, fold the taps back in when a 1 falls out.
  function automatic logic [ALU_W-1:0] lfsr_next(input logic [ALU_W-1:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

  function automatic logic [ALU_W-1:0] alu_ref(input alu_op_e op,
                                               input logic [ALU_W-1:0] a,
                                               input logic [ALU_W-1:0] b);
    logic big;
    big = |b[ALU_W-1:5];
    case (op)
      OP_AND:  alu_ref = a & b;
      OP_OR:   alu_ref = a | b;
      OP_ADD:  alu_ref = a + b;
      OP_XOR:  alu_ref = a ^ b;
      OP_SLL:  alu_ref = big ? '0 : (a << b[4:0]);
      OP_SRL:  alu_ref = big ? '0 : (a >> b[4:0]);
      OP_SUB:  alu_ref = a - b;
      OP_SRA:  alu_ref = big ? {ALU_W{a[ALU_W-1]}} : ALU_W'($signed(a) >>> b[4:0]);
      default: alu_ref = '0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR; each step pulse consumes two values (one per ALU operand).
module lfsr32
  import alu_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q,
  output logic [31:0] q_next
);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)      q_d = seed;
    else if (step) q_d = lfsr_next(lfsr_next(q_q));
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  assign q      = q_q;
  assign q_next = lfsr_next(q_q);

endmodule

// File: rtl/alu_bist.sv
// Built-in self test for the 8-op ALU: drives LFSR operands, checks result and zero flag.
module alu_bist
  import alu_pkg::*;
#(
  parameter int unsigned ROUNDS = 25,
  parameter logic [31:0] SEED   = 32'hACE1_2345,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_c,
  input  logic        alu_zero
);

  localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [11:0] ROUNDS_W    = 12'(ROUNDS);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_WAIT, S_CHECK, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [11:0] round_q, round_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] pass_q, pass_d, fail_q, fail_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        lfsr_load, lfsr_step;
  logic [31:0] lfsr_q, lfsr_nxt;
  logic        c_ok, z_ok;
  logic [1:0]  n_ok;

  lfsr32 #(.RESET_VAL(SEED_EFF)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lfsr_load),
    .seed   (SEED_EFF),
    .step   (lfsr_step),
    .q      (lfsr_q),
    .q_next (lfsr_nxt)
  );

  function automatic logic [15:0] sat_add(input logic [15:0] x, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, x} + {15'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // The zero check uses the observed result so a wrong c is not counted twice.
  assign c_ok = (alu_c == alu_ref(alu_op_e'(ctl_q), a_q, b_q));
  assign z_ok = (alu_zero == (alu_c == 32'h0));
  assign n_ok = {1'b0, c_ok} + {1'b0, z_ok};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    round_d   = round_q;
    wait_d    = wait_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ctl_d     = ctl_q;
    a_d       = a_q;
    b_d       = b_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        pass_d    = '0;
        fail_d    = '0;
        op_d      = '0;
        round_d   = '0;
        lfsr_load = 1'b1;
        state_d   = S_GEN;
      end
      S_GEN: begin
        a_d       = lfsr_q;
        b_d       = (op_q == 3'd7) ? {27'b0, lfsr_nxt[4:0]} : lfsr_nxt;
        ctl_d     = {1'b0, op_q};
        lfsr_step = 1'b1;
        wait_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == SETTLE_LAST) state_d = S_CHECK;
        else                       wait_d  = wait_q + 4'd1;
      end
      S_CHECK: begin
        pass_d  = sat_add(pass_q, n_ok);
        fail_d  = sat_add(fail_q, 2'd2 - n_ok);
        op_d    = op_q + 3'd1;
        state_d = S_GEN;
        if (op_q == 3'd7) begin
          round_d = round_q + 12'd1;
          if (round_q + 12'd1 == ROUNDS_W) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      round_q <= '0;
      wait_q  <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      round_q <= round_d;
      wait_q  <= wait_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy        = (state_q == S_GEN) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done        = (state_q == S_DONE);
  assign pass_count  = pass_q;
  assign fail_count  = fail_q;
  assign alu_control = ctl_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU with fault modes, operand scoreboard, count model.
module tb_alu_bist;

  localparam int          R0 = 25, S0 = 1;
  localparam logic [31:0] SEED0 = 32'hACE1_2345;
  localparam int          R1 = 1, S1 = 3;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start   [2];
  logic        busy    [2];
  logic        done    [2];
  logic [15:0] pass_c  [2];
  logic [15:0] fail_c  [2];
  logic [3:0]  ctl     [2];
  logic [31:0] a       [2];
  logic [31:0] b       [2];
  logic [31:0] c       [2];
  logic        zero    [2];
  int          fault   [2];

  int   total = 0;
  int   bad   = 0;
  txn_t sb[$];

  always #5 clk = ~clk;

  // fault 1: op 7 shifts logically; fault 2: zero flag stuck at 0
  function automatic logic [31:0] tb_alu(input int f, input logic [3:0] op,
                                         input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ext;
    logic [31:0] r;
    r = 32'h0;
    case (op)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x + y;
      4'd3: r = x ^ y;
      4'd4: r = (y > 32'd31) ? 32'h0 : (x << y[4:0]);
      4'd5: r = (y > 32'd31) ? 32'h0 : (x >> y[4:0]);
      4'd6: r = x - y;
      4'd7: begin
        if (f == 1) r = (y > 32'd31) ? 32'h0 : (x >> y[4:0]);
        else begin
          ext = {{32{x[31]}}, x} >> y[4:0];
          r   = (y > 32'd31) ? {32{x[31]}} : ext[31:0];
        end
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] tb_lfsr(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  assign c[0]    = tb_alu(fault[0], ctl[0], a[0], b[0]);
  assign zero[0] = (fault[0] == 2) ? 1'b0 : (c[0] == 32'h0);
  assign c[1]    = tb_alu(fault[1], ctl[1], a[1], b[1]);
  assign zero[1] = (fault[1] == 2) ? 1'b0 : (c[1] == 32'h0);

  alu_bist u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass_count(pass_c[0]), .fail_count(fail_c[0]), .alu_control(ctl[0]),
    .alu_a(a[0]), .alu_b(b[0]), .alu_c(c[0]), .alu_zero(zero[0])
  );

  alu_bist #(.ROUNDS(R1), .SEED(32'h0), .SETTLE(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass_count(pass_c[1]), .fail_count(fail_c[1]), .alu_control(ctl[1]),
    .alu_a(a[1]), .alu_b(b[1]), .alu_c(c[1]), .alu_zero(zero[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check({tag, " busy"}, 128'(busy[d]), 128'(0));
    check({tag, " done"}, 128'(done[d]), 128'(0));
    check({tag, " counts"}, 128'({pass_c[d], fail_c[d]}), 128'(0));
    check({tag, " alu_drive"}, 128'({ctl[d], a[d], b[d]}), 128'(0));
  endtask

  // Start a run on DUT d with start held for 'hold' cycles; scoreboard operands and counts.
  task automatic run_check(input int d, input int hold, input string tag);
    logic [31:0] lf, oc, rc;
    int   rounds, period, nops, exp_pass, exp_fail, zf, done_at;
    bit   seen_done;
    txn_t t;
    rounds   = (d == 0) ? R0 : R1;
    period   = ((d == 0) ? S0 : S1) + 2;
    lf       = (d == 0) ? SEED0 : 32'h1;
    nops     = 8 * rounds;
    exp_pass = 0;
    exp_fail = 0;
    sb.delete();
    for (int k = 0; k < nops; k++) begin
      t.op = 4'(k % 8);
      t.a  = lf;
      lf   = tb_lfsr(lf);
      t.b  = lf;
      lf   = tb_lfsr(lf);
      if (t.op == 4'd7) t.b = {27'b0, t.b[4:0]};
      sb.push_back(t);
      oc = tb_alu(fault[d], t.op, t.a, t.b);
      rc = tb_alu(0, t.op, t.a, t.b);
      zf = (fault[d] == 2) ? 0 : ((oc == 32'h0) ? 1 : 0);
      if (oc == rc) exp_pass++; else exp_fail++;
      if (zf == ((oc == 32'h0) ? 1 : 0)) exp_pass++; else exp_fail++;
    end
    done_at   = nops * period + 1;
    seen_done = 0;
    for (int i = 0; i <= done_at + 20 && !seen_done; i++) begin
      @(negedge clk);
      if (i == 1) check({tag, " busy_after_start"}, 128'(busy[d]), 128'(1));
      if (i >= 2 && ((i - 2) % period) == 0 && sb.size() > 0) begin
        t = sb.pop_front();
        check({tag, " operands"}, 128'({ctl[d], a[d], b[d]}), 128'({t.op, t.a, t.b}));
      end
      if (done[d]) begin
        seen_done = 1;
        check({tag, " done_cycle"}, 128'(i), 128'(done_at));
        check({tag, " busy_in_done"}, 128'(busy[d]), 128'(0));
        check({tag, " pass"}, 128'(pass_c[d]), 128'(exp_pass));
        check({tag, " fail"}, 128'(fail_c[d]), 128'(exp_fail));
      end
      start[d] = (i < hold);
    end
    start[d] = 1'b0;
    if (!seen_done) check({tag, " done_timeout"}, 128'(0), 128'(1));
    check({tag, " sb_empty"}, 128'(sb.size()), 128'(0));
    @(negedge clk);
    check({tag, " done_pulse"}, 128'(done[d]), 128'(0));
    repeat (4) @(negedge clk);
    check({tag, " hold_counts"}, 128'({pass_c[d], fail_c[d]}), 128'({exp_pass[15:0], exp_fail[15:0]}));
  endtask

  initial begin
    fault[0] = 0;
    fault[1] = 0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals(0, "reset0");
    check_reset_vals(1, "reset1");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_check(0, 1, "good");
    run_check(0, 10, "hold10");
    fault[0] = 1;
    run_check(0, 1, "sra_bug");
    fault[0] = 0;
    run_check(1, 1, "seed0");
    fault[1] = 2;
    run_check(1, 1, "zero_stuck");
    fault[1] = 0;

    // Abort a run mid-flight; outputs must clear asynchronously.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(0, "abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_check(0, 1, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
